// File: rtl/and3_monitor_if.sv
// Observation bundle for the and3 DUT: the three inputs and the output, all sampled by the monitor.
interface and3_monitor_if;
  logic i1;
  logic i2;
  logic i3;
  logic o1;

  modport master (output i1, i2, i3, o1);
  modport slave  (input  i1, i2, i3, o1);
endinterface

// File: rtl/and3_monitor.sv
// Passive response checker for and3: predicts o1 = i1&i2&i3, delays it by LATENCY, compares,
// and keeps saturating check/error/cycle counts with first-error capture and optional halt.
//
// state | meaning
// IDLE  | not sampling; pipeline empty; entered from reset, clear or enable low
// RUN   | sampling every edge, comparing once the pipeline holds LATENCY samples
// HALT  | error limit reached; everything frozen until clear or reset
module and3_monitor #(
  parameter int LATENCY    = 1,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_ERRORS = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  and3_monitor_if.slave        bus,
  output logic [CNT_WIDTH-1:0] check_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] first_err_cycle,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 halted
);

  localparam int                   PD      = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [31:0]          MAX_E   = 32'(MAX_ERRORS);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state;
  logic [PD-1:0]        exp_pipe;
  logic [PD-1:0]        vld_pipe;
  logic                 exp_now;
  logic                 exp_out;
  logic                 vld_out;
  logic                 mismatch;
  logic                 halt_hit;
  logic [CNT_WIDTH-1:0] err_next;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  assign exp_now = bus.i1 & bus.i2 & bus.i3;

  // Zero latency compares against the same-edge prediction; the pipe registers go unused.
  generate
    if (LATENCY == 0) begin : g_comb
      assign exp_out = exp_now;
      assign vld_out = 1'b1;
    end else begin : g_pipe
      assign exp_out = exp_pipe[PD-1];
      assign vld_out = vld_pipe[PD-1];
    end
  endgenerate

  // Case inequality so an X or Z on o1 is reported rather than silently matching.
  assign mismatch = (bus.o1 !== exp_out);
  assign err_next = sat_inc(error_count);
  assign halt_hit = (MAX_E != 32'd0) && (32'(err_next) >= MAX_E);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      exp_pipe        <= '0;
      vld_pipe        <= '0;
      check_count     <= '0;
      error_count     <= '0;
      error           <= 1'b0;
      first_err_cycle <= '0;
      cycle_count     <= '0;
      halted          <= 1'b0;
    end else if (clear) begin
      state           <= IDLE;
      exp_pipe        <= '0;
      vld_pipe        <= '0;
      check_count     <= '0;
      error_count     <= '0;
      error           <= 1'b0;
      first_err_cycle <= '0;
      cycle_count     <= '0;
      halted          <= 1'b0;
    end else begin
      case (state)
        HALT: begin
        end
        default: begin
          if (!enable) begin
            state    <= IDLE;
            vld_pipe <= '0;
          end else begin
            // The edge that enters RUN already samples, so the first compare lands LATENCY edges later.
            state       <= RUN;
            exp_pipe[0] <= exp_now;
            vld_pipe[0] <= 1'b1;
            for (int i = 1; i < PD; i++) begin
              exp_pipe[i] <= exp_pipe[i-1];
              vld_pipe[i] <= vld_pipe[i-1];
            end
            cycle_count <= sat_inc(cycle_count);
            if (vld_out) begin
              check_count <= sat_inc(check_count);
              if (mismatch) begin
                error_count <= err_next;
                if (!error) begin
                  error           <= 1'b1;
                  first_err_cycle <= cycle_count;
                end
                if (halt_hit) begin
                  state  <= HALT;
                  halted <= 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and3_monitor.sv
// Bench for and3_monitor: five monitor instances with different parameters, each tracked by a
// sample-count based reference model and exercised with randomized and directed stimulus.
module tb_and3_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  in_v;
  logic [4:0]  o1_v;
  logic [4:0]  en_v;
  logic [4:0]  clr_v;

  logic [15:0] d_chk[5];
  logic [15:0] d_err[5];
  logic [15:0] d_first[5];
  logic [15:0] d_cyc[5];
  logic        d_error[5];
  logic        d_halt[5];
  logic [3:0]  s_chk, s_err, s_first, s_cyc;

  int errors = 0;
  int checks = 0;

  // Reference model: instance parameters plus per-instance observable state.
  int m_lat[5] = '{1, 1, 4, 1, 0};
  int m_max[5] = '{0, 3, 0, 0, 0};
  int m_sat[5] = '{65535, 65535, 65535, 15, 65535};
  int m_fill[5], m_chk[5], m_err[5], m_first[5], m_cyc[5];
  bit m_errf[5], m_halt[5];
  bit m_hist[5][16];

  and3_monitor_if b0 ();
  and3_monitor_if b1 ();
  and3_monitor_if b2 ();
  and3_monitor_if b3 ();
  and3_monitor_if b4 ();

  assign {b0.i1, b0.i2, b0.i3, b0.o1} = {in_v, o1_v[0]};
  assign {b1.i1, b1.i2, b1.i3, b1.o1} = {in_v, o1_v[1]};
  assign {b2.i1, b2.i2, b2.i3, b2.o1} = {in_v, o1_v[2]};
  assign {b3.i1, b3.i2, b3.i3, b3.o1} = {in_v, o1_v[3]};
  assign {b4.i1, b4.i2, b4.i3, b4.o1} = {in_v, o1_v[4]};

  and3_monitor #(.LATENCY(1), .CNT_WIDTH(16), .MAX_ERRORS(0)) u0 (
    .clk(clk), .reset(reset), .enable(en_v[0]), .clear(clr_v[0]), .bus(b0.slave),
    .check_count(d_chk[0]), .error_count(d_err[0]), .error(d_error[0]),
    .first_err_cycle(d_first[0]), .cycle_count(d_cyc[0]), .halted(d_halt[0]));

  and3_monitor #(.LATENCY(1), .CNT_WIDTH(16), .MAX_ERRORS(3)) u1 (
    .clk(clk), .reset(reset), .enable(en_v[1]), .clear(clr_v[1]), .bus(b1.slave),
    .check_count(d_chk[1]), .error_count(d_err[1]), .error(d_error[1]),
    .first_err_cycle(d_first[1]), .cycle_count(d_cyc[1]), .halted(d_halt[1]));

  and3_monitor #(.LATENCY(4), .CNT_WIDTH(16), .MAX_ERRORS(0)) u2 (
    .clk(clk), .reset(reset), .enable(en_v[2]), .clear(clr_v[2]), .bus(b2.slave),
    .check_count(d_chk[2]), .error_count(d_err[2]), .error(d_error[2]),
    .first_err_cycle(d_first[2]), .cycle_count(d_cyc[2]), .halted(d_halt[2]));

  and3_monitor #(.LATENCY(1), .CNT_WIDTH(4), .MAX_ERRORS(0)) u3 (
    .clk(clk), .reset(reset), .enable(en_v[3]), .clear(clr_v[3]), .bus(b3.slave),
    .check_count(s_chk), .error_count(s_err), .error(d_error[3]),
    .first_err_cycle(s_first), .cycle_count(s_cyc), .halted(d_halt[3]));

  assign d_chk[3]   = {12'd0, s_chk};
  assign d_err[3]   = {12'd0, s_err};
  assign d_first[3] = {12'd0, s_first};
  assign d_cyc[3]   = {12'd0, s_cyc};

  and3_monitor #(.LATENCY(0), .CNT_WIDTH(16), .MAX_ERRORS(0)) u4 (
    .clk(clk), .reset(reset), .enable(en_v[4]), .clear(clr_v[4]), .bus(b4.slave),
    .check_count(d_chk[4]), .error_count(d_err[4]), .error(d_error[4]),
    .first_err_cycle(d_first[4]), .cycle_count(d_cyc[4]), .halted(d_halt[4]));

  function automatic int sat(int v, int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 5; m++) begin
      m_fill[m] = 0; m_chk[m] = 0; m_err[m] = 0; m_first[m] = 0; m_cyc[m] = 0;
      m_errf[m] = 0; m_halt[m] = 0;
      for (int j = 0; j < 16; j++) m_hist[m][j] = 0;
    end
  endfunction

  // One rising edge of monitor m: m_fill counts samples taken since the last (re)arm.
  function automatic void model_step(int m);
    bit e;
    bit expv;
    bit cmp;
    e = &in_v;
    if (clr_v[m]) begin
      m_fill[m] = 0; m_chk[m] = 0; m_err[m] = 0; m_first[m] = 0; m_cyc[m] = 0;
      m_errf[m] = 0; m_halt[m] = 0;
    end else if (m_halt[m]) begin
      m_fill[m] = m_fill[m];
    end else if (!en_v[m]) begin
      m_fill[m] = 0;
    end else begin
      cmp  = (m_fill[m] >= m_lat[m]);
      expv = (m_lat[m] == 0) ? e : m_hist[m][(m_fill[m] - m_lat[m]) % 16];
      m_hist[m][m_fill[m] % 16] = e;
      m_fill[m]++;
      if (cmp) begin
        m_chk[m] = sat(m_chk[m], m_sat[m]);
        if (o1_v[m] !== expv) begin
          if (!m_errf[m]) begin
            m_first[m] = m_cyc[m];
            m_errf[m]  = 1;
          end
          m_err[m] = sat(m_err[m], m_sat[m]);
          if (m_max[m] != 0 && m_err[m] >= m_max[m]) m_halt[m] = 1;
        end
      end
      m_cyc[m] = sat(m_cyc[m], m_sat[m]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 5; m++) model_step(m);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_v = '0; o1_v = '0; en_v = '0; clr_v = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (d_chk[k] !== 16'd0 || d_err[k] !== 16'd0 || d_error[k] !== 1'b0 ||
          d_first[k] !== 16'd0 || d_cyc[k] !== 16'd0 || d_halt[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset k=%0d got chk=%0d err=%0d error=%b first=%0d cyc=%0d halt=%b want all 0",
                 k, d_chk[k], d_err[k], d_error[k], d_first[k], d_cyc[k], d_halt[k]);
      end
      checks++;
    end
    #4 reset = 1'b0;
  endtask

  task automatic test_correct();
    bit prev_and = 0;
    en_v[0] = 1'b1;
    for (int t = 0; t < 17; t++) begin
      in_v    = 3'(t % 8);
      o1_v[0] = prev_and;
      prev_and = &in_v;
      tick();
      if (d_chk[0] !== 16'(m_chk[0]) || d_err[0] !== 16'(m_err[0]) || d_error[0] !== m_errf[0] ||
          d_cyc[0] !== 16'(m_cyc[0]) || d_halt[0] !== m_halt[0]) begin
        errors++;
        $display("FAIL correct t=%0d got chk=%0d err=%0d error=%b cyc=%0d want %0d %0d %b %0d",
                 t, d_chk[0], d_err[0], d_error[0], d_cyc[0], m_chk[0], m_err[0], m_errf[0], m_cyc[0]);
      end
      checks++;
    end
    if (d_chk[0] !== 16'd16 || d_err[0] !== 16'd0 || d_error[0] !== 1'b0) begin
      errors++;
      $display("FAIL correct_totals got chk=%0d err=%0d error=%b want 16 0 0", d_chk[0], d_err[0], d_error[0]);
    end
    checks++;
    en_v[0] = 1'b0;
    tick();
  endtask

  task automatic test_stuck();
    clr_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    en_v[0]  = 1'b1;
    o1_v[0]  = 1'b1;
    for (int t = 0; t < 11; t++) begin
      in_v = (t % 2 == 0) ? 3'b000 : 3'b111;
      tick();
      if (d_chk[0] !== 16'(m_chk[0]) || d_err[0] !== 16'(m_err[0]) || d_error[0] !== m_errf[0] ||
          d_first[0] !== 16'(m_first[0])) begin
        errors++;
        $display("FAIL stuck t=%0d got chk=%0d err=%0d error=%b first=%0d want %0d %0d %b %0d",
                 t, d_chk[0], d_err[0], d_error[0], d_first[0], m_chk[0], m_err[0], m_errf[0], m_first[0]);
      end
      checks++;
    end
    if (d_chk[0] !== 16'd10 || d_err[0] !== 16'd5 || d_error[0] !== 1'b1 || d_first[0] !== 16'd1) begin
      errors++;
      $display("FAIL stuck_totals got chk=%0d err=%0d error=%b first=%0d want 10 5 1 1",
               d_chk[0], d_err[0], d_error[0], d_first[0]);
    end
    checks++;
    en_v[0] = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    en_v[1] = 1'b1;
    in_v    = 3'b111;
    o1_v[1] = 1'b0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (d_chk[1] !== 16'(m_chk[1]) || d_err[1] !== 16'(m_err[1]) || d_halt[1] !== m_halt[1] ||
          d_cyc[1] !== 16'(m_cyc[1]) || d_first[1] !== 16'(m_first[1])) begin
        errors++;
        $display("FAIL halt t=%0d got chk=%0d err=%0d halt=%b cyc=%0d first=%0d want %0d %0d %b %0d %0d",
                 t, d_chk[1], d_err[1], d_halt[1], d_cyc[1], d_first[1],
                 m_chk[1], m_err[1], m_halt[1], m_cyc[1], m_first[1]);
      end
      checks++;
      if (t >= 3 && (d_halt[1] !== 1'b1 || d_err[1] !== 16'd3)) begin
        errors++;
        $display("FAIL halt_frozen t=%0d got halt=%b err=%0d want 1 3", t, d_halt[1], d_err[1]);
      end
      if (t >= 3) checks++;
    end
    clr_v[1] = 1'b1;
    tick();
    clr_v[1] = 1'b0;
    en_v[1]  = 1'b0;
    if (d_chk[1] !== 16'd0 || d_err[1] !== 16'd0 || d_error[1] !== 1'b0 || d_halt[1] !== 1'b0 ||
        d_cyc[1] !== 16'd0 || d_first[1] !== 16'd0) begin
      errors++;
      $display("FAIL halt_clear got chk=%0d err=%0d error=%b halt=%b cyc=%0d want all 0",
               d_chk[1], d_err[1], d_error[1], d_halt[1], d_cyc[1]);
    end
    checks++;
    tick();
  endtask

  task automatic test_enable_gap();
    bit andh[$];
    int c0;
    for (int t = 0; t < 24; t++) begin
      en_v[2] = !(t == 10 || t == 11);
      in_v    = 3'($urandom_range(0, 7));
      andh.push_back(&in_v);
      o1_v[2] = (andh.size() > 4) ? andh[andh.size() - 5] : 1'b0;
      tick();
      if (t == 9) c0 = m_chk[2];
      if (d_chk[2] !== 16'(m_chk[2]) || d_err[2] !== 16'(m_err[2]) || d_error[2] !== m_errf[2] ||
          d_cyc[2] !== 16'(m_cyc[2])) begin
        errors++;
        $display("FAIL gap t=%0d got chk=%0d err=%0d error=%b cyc=%0d want %0d %0d %b %0d",
                 t, d_chk[2], d_err[2], d_error[2], d_cyc[2], m_chk[2], m_err[2], m_errf[2], m_cyc[2]);
      end
      checks++;
      if (t == 15 && d_chk[2] !== 16'(c0)) begin
        errors++;
        $display("FAIL gap_refill got chk=%0d want %0d", d_chk[2], c0);
      end
      if (t == 16 && d_chk[2] !== 16'(c0 + 1)) begin
        errors++;
        $display("FAIL gap_resume got chk=%0d want %0d", d_chk[2], c0 + 1);
      end
      if (t == 15 || t == 16) checks++;
    end
    if (d_error[2] !== 1'b0) begin
      errors++;
      $display("FAIL gap_no_error got error=%b want 0", d_error[2]);
    end
    checks++;
    en_v[2] = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    en_v[3] = 1'b1;
    in_v    = 3'b111;
    o1_v[3] = 1'b0;
    for (int t = 0; t < 21; t++) begin
      tick();
      if (d_chk[3] !== 16'(m_chk[3]) || d_err[3] !== 16'(m_err[3]) || d_cyc[3] !== 16'(m_cyc[3]) ||
          d_first[3] !== 16'(m_first[3]) || d_error[3] !== m_errf[3]) begin
        errors++;
        $display("FAIL sat t=%0d got chk=%0d err=%0d cyc=%0d first=%0d want %0d %0d %0d %0d",
                 t, d_chk[3], d_err[3], d_cyc[3], d_first[3], m_chk[3], m_err[3], m_cyc[3], m_first[3]);
      end
      checks++;
    end
    if (d_chk[3] !== 16'd15 || d_err[3] !== 16'd15 || d_cyc[3] !== 16'd15 || d_error[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_totals got chk=%0d err=%0d cyc=%0d error=%b want 15 15 15 1",
               d_chk[3], d_err[3], d_cyc[3], d_error[3]);
    end
    checks++;
    en_v[3] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit prev_and = 0;
    en_v[0] = 1'b1;
    o1_v[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      in_v = 3'($urandom_range(0, 7));
      tick();
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    if (d_chk[0] !== 16'd0 || d_err[0] !== 16'd0 || d_error[0] !== 1'b0 ||
        d_first[0] !== 16'd0 || d_cyc[0] !== 16'd0 || d_halt[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got chk=%0d err=%0d error=%b first=%0d cyc=%0d want all 0",
               d_chk[0], d_err[0], d_error[0], d_first[0], d_cyc[0]);
    end
    checks++;
    #2 reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_v    = 3'($urandom_range(0, 7));
      o1_v[0] = prev_and;
      prev_and = &in_v;
      tick();
      if (d_chk[0] !== 16'(t) || d_chk[0] !== 16'(m_chk[0]) || d_err[0] !== 16'(m_err[0])) begin
        errors++;
        $display("FAIL reset_refill t=%0d got chk=%0d err=%0d want %0d %0d", t, d_chk[0], d_err[0], t, m_err[0]);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit prev_and = 0;
    for (int t = 0; t < 400; t++) begin
      in_v     = 3'($urandom_range(0, 7));
      en_v[0]  = ($urandom_range(0, 5) != 0);
      en_v[4]  = ($urandom_range(0, 5) != 0);
      clr_v[0] = ($urandom_range(0, 40) == 0);
      clr_v[4] = ($urandom_range(0, 40) == 0);
      o1_v[0]  = prev_and ^ ($urandom_range(0, 9) == 0);
      o1_v[4]  = (&in_v) ^ ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 30) == 0) o1_v[4] = 1'bx;
      prev_and = &in_v;
      tick();
      for (int k = 0; k < 5; k += 4) begin
        if (d_chk[k] !== 16'(m_chk[k]) || d_err[k] !== 16'(m_err[k]) || d_error[k] !== m_errf[k] ||
            d_first[k] !== 16'(m_first[k]) || d_cyc[k] !== 16'(m_cyc[k]) || d_halt[k] !== m_halt[k]) begin
          errors++;
          $display("FAIL random t=%0d k=%0d got chk=%0d err=%0d error=%b first=%0d cyc=%0d want %0d %0d %b %0d %0d",
                   t, k, d_chk[k], d_err[k], d_error[k], d_first[k], d_cyc[k],
                   m_chk[k], m_err[k], m_errf[k], m_first[k], m_cyc[k]);
        end
        checks++;
      end
    end
    en_v  = '0;
    clr_v = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck();
    test_halt();
    test_enable_gap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
